// File: rtl/aes_dec_pkg.sv
// -----------------------------------------------------------------------------
// aes_dec_pkg
// Shared types, constants and GF(2^8) helpers for the iterative AES decryption
// sequencer (aes_inv_cipher_ctrl) and its round datapath (aes_inv_round).
//   NR_128/NR_192/NR_256 : round counts for the three AES key sizes
//   block_t              : 128-bit block, byte 0 = bits [0:7]
//   state_e              : sequencer FSM states (SUB only used when
//                          AES_DEC_SBOX_PIPE_EN is defined)
// -----------------------------------------------------------------------------
package aes_dec_pkg;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  typedef logic [0:127] block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUB   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse S-box from its algebraic definition: undo the affine map, then
  // take the multiplicative inverse as a^254 (which also maps 0 to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] a;
    logic [7:0] sq;
    logic [7:0] r;
    a  = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_ctrl_if.sv
// -----------------------------------------------------------------------------
// aes_inv_cipher_ctrl_if
// Handshake/bus bundle of the AES decryption sequencer.
//   in_valid/in_ready/in_data    : ciphertext input handshake
//   key_idx/round_key            : round-key fetch from the expanded-key store
//   out_valid/out_ready/out_data : plaintext output handshake
//   busy                         : sequencer not in IDLE
// Modports: slave = sequencer side, master = system / key-store side.
// -----------------------------------------------------------------------------
interface aes_inv_cipher_ctrl_if import aes_dec_pkg::*; #(
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  block_t           in_data;
  logic [CNT_W-1:0] key_idx;
  block_t           round_key;
  logic             out_valid;
  logic             out_ready;
  block_t           out_data;
  logic             busy;

  modport slave (
    input  in_valid, in_data, round_key, out_ready,
    output in_ready, key_idx, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, round_key, out_ready,
    input  in_ready, key_idx, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_inv_round.sv
// -----------------------------------------------------------------------------
// aes_inv_round
// Combinational AES inverse round:
//   InvShiftRows -> InvSubState -> AddRoundKey -> InvMixColumns (skipped on last)
// Ports:
//   state   : round input block
//   key     : round key
//   last    : final round, suppresses InvMixColumns
//   result  : round output block
// With AES_DEC_SBOX_PIPE_EN defined the round is split in two halves:
//   sub_out : InvSubState(InvShiftRows(state)), to be registered by the caller
//   sub_in  : registered sub_out, feeding AddRoundKey/InvMixColumns
// -----------------------------------------------------------------------------
module aes_inv_round import aes_dec_pkg::*; (
  input  block_t state,
`ifdef AES_DEC_SBOX_PIPE_EN
  input  block_t sub_in,
  output block_t sub_out,
`endif
  input  block_t key,
  input  logic   last,
  output block_t result
);

  // Byte 4*c+r is row r of column c; row r rotates right by r columns.
  function automatic block_t inv_shift_rows(input block_t s);
    block_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = s[8*(4*((c-r) & 3)+r) +: 8];
    return o;
  endfunction

  function automatic block_t inv_sub_state(input block_t s);
    block_t o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic block_t inv_mix_columns(input block_t s);
    block_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(4*c)   +: 8];
      a1 = s[8*(4*c+1) +: 8];
      a2 = s[8*(4*c+2) +: 8];
      a3 = s[8*(4*c+3) +: 8];
      o[8*(4*c)   +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[8*(4*c+1) +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[8*(4*c+2) +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[8*(4*c+3) +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  block_t keyed;

`ifdef AES_DEC_SBOX_PIPE_EN
  assign sub_out = inv_sub_state(inv_shift_rows(state));
  assign keyed   = sub_in ^ key;
`else
  assign keyed   = inv_sub_state(inv_shift_rows(state)) ^ key;
`endif

  assign result = last ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// -----------------------------------------------------------------------------
// aes_inv_cipher_ctrl
// Iterative AES decryption sequencer: loads a ciphertext (XOR key NR), then
// runs one inverse round per cycle, fetching round key cnt from an external
// combinational key store, and presents the plaintext until accepted.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : aes_inv_cipher_ctrl_if.slave (ciphertext in, key fetch,
//           plaintext out, busy)
// Parameters: NR (10/12/14 rounds), CNT_W (2^CNT_W > NR).
// Option: define AES_DEC_SBOX_PIPE_EN to register the InvSubState output,
// making every round two cycles (SUB then ROUND).
// -----------------------------------------------------------------------------
module aes_inv_cipher_ctrl import aes_dec_pkg::*; #(
  parameter int NR    = NR_128,
  parameter int CNT_W = 4
) (
  input logic                  clk,
  input logic                  reset,
  aes_inv_cipher_ctrl_if.slave bus
);

`ifdef AES_DEC_SBOX_PIPE_EN
  localparam state_e ROUND_ENTRY = SUB;
`else
  localparam state_e ROUND_ENTRY = ROUND;
`endif

  state_e           state_q, state_d;
  block_t           data_q, data_d;
  block_t           round_out;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;

  assign last = (cnt_q == '0);

`ifdef AES_DEC_SBOX_PIPE_EN
  block_t sub_q;
  block_t sub_out;

  aes_inv_round u_round (
    .state  (data_q),
    .sub_in (sub_q),
    .sub_out(sub_out),
    .key    (bus.round_key),
    .last   (last),
    .result (round_out)
  );

  // NOTE: sub_q has no reset; it is always written in SUB before ROUND reads it.
  always_ff @(posedge clk) begin
    if (state_q == SUB) sub_q <= sub_out;
  end
`else
  aes_inv_round u_round (
    .state (data_q),
    .key   (bus.round_key),
    .last  (last),
    .result(round_out)
  );
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // in_ready is high in IDLE, so in_valid alone completes the accept.
        if (bus.in_valid) begin
          data_d  = bus.in_data ^ bus.round_key;
          cnt_d   = CNT_W'(NR - 1);
          state_d = ROUND_ENTRY;
        end
      end
`ifdef AES_DEC_SBOX_PIPE_EN
      SUB:   state_d = ROUND;
`else
      SUB:   state_d = IDLE;
`endif
      ROUND: begin
        data_d = round_out;
        if (last) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = ROUND_ENTRY;
        end
      end
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = (state_q == DONE) ? data_q : '0;
  assign bus.key_idx   = (state_q == IDLE) ? CNT_W'(NR) : cnt_q;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_cipher_ctrl
// Directed bench for aes_inv_cipher_ctrl using FIPS-197 vectors C.1 (NR=10)
// and C.3 (NR=14, second instance). The bench builds the forward S-box and
// expands the cipher keys itself to act as the external key store.
// Honours AES_DEC_SBOX_PIPE_EN (two cycles per round).
// -----------------------------------------------------------------------------
module tb_aes_inv_cipher_ctrl;
  import aes_dec_pkg::*;

  localparam int CNT_W = 4;
`ifdef AES_DEC_SBOX_PIPE_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  localparam block_t C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam block_t C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam block_t PT    = 128'h00112233445566778899aabbccddeeff;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  always @(posedge clk) cyc <= cyc + 1;

  aes_inv_cipher_ctrl_if #(.CNT_W(CNT_W)) bus_a ();
  aes_inv_cipher_ctrl_if #(.CNT_W(CNT_W)) bus_b ();

  aes_inv_cipher_ctrl #(.NR(NR_128), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  aes_inv_cipher_ctrl #(.NR(NR_256), .CNT_W(CNT_W)) dut256 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  logic [7:0] sbox [256];
  block_t     rk128 [15];
  block_t     rk256 [15];

  assign bus_a.round_key = (bus_a.key_idx <= 4'd14) ? rk128[bus_a.key_idx] : '0;
  assign bus_b.round_key = (bus_b.key_idx <= 4'd14) ? rk256[bus_b.key_idx] : '0;

  // ---------------- key store model ----------------
  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    return 8'((v << s) | (v >> (8 - s)));
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ 8'(p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ 8'(q << 1);
      q = q ^ 8'(q << 2);
      q = q ^ 8'(q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  task automatic expand_key(input logic [0:255] key, input int nk, input int nr, input bit is256);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      if (is256) rk256[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else       rk128[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    vectors++; if (bus_a.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus_a.in_ready); end
    vectors++; if (bus_a.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
    vectors++; if (bus_a.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus_a.out_valid); end
    vectors++; if (bus_a.out_data !== '0) begin miscompares++; $display("FAIL reset_out_data: got %h want 0", bus_a.out_data); end
    vectors++; if (bus_a.key_idx !== 4'd10) begin miscompares++; $display("FAIL reset_key_idx: got %0d want 10", bus_a.key_idx); end
    vectors++; if (bus_b.key_idx !== 4'd14) begin miscompares++; $display("FAIL reset_key_idx_256: got %0d want 14", bus_b.key_idx); end
  endtask

  // Decrypts one block on the NR=10 instance with out_ready high, tracing
  // key_idx each cycle and checking latency, plaintext and return to IDLE.
  task automatic decrypt_a(input block_t ct, input string tag);
    int n;
    logic [3:0] exp_k;
    @(negedge clk);
    bus_a.out_ready = 1'b1;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = ct;
    vectors++; if (bus_a.in_ready !== 1'b1) begin miscompares++; $display("FAIL %s_in_ready: got %b want 1", tag, bus_a.in_ready); end
    vectors++; if (bus_a.key_idx !== 4'd10) begin miscompares++; $display("FAIL %s_key_idle: got %0d want 10", tag, bus_a.key_idx); end
    @(posedge clk);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = ~ct;
    n = 0;
    while (!bus_a.out_valid && n < 60) begin
      exp_k = 4'(NR_128 - 1 - n / STEP);
      vectors++; if (bus_a.key_idx !== exp_k) begin miscompares++; $display("FAIL %s_key_idx[%0d]: got %0d want %0d", tag, n, bus_a.key_idx, exp_k); end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    vectors++; if (n !== STEP * NR_128) begin miscompares++; $display("FAIL %s_latency: got %0d want %0d", tag, n, STEP * NR_128); end
    vectors++; if (bus_a.out_data !== PT) begin miscompares++; $display("FAIL %s_out_data: got %h want %h", tag, bus_a.out_data, PT); end
    @(posedge clk);
    @(negedge clk);
    vectors++; if (bus_a.out_valid !== 1'b0) begin miscompares++; $display("FAIL %s_release_valid: got %b want 0", tag, bus_a.out_valid); end
    vectors++; if (bus_a.out_data !== '0) begin miscompares++; $display("FAIL %s_release_data: got %h want 0", tag, bus_a.out_data); end
    vectors++; if (bus_a.in_ready !== 1'b1) begin miscompares++; $display("FAIL %s_release_ready: got %b want 1", tag, bus_a.in_ready); end
  endtask

  task automatic test_c1();
    decrypt_a(C1_CT, "c1");
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = C1_CT;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (!bus_a.out_valid && n < 60) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    vectors++; if (n !== STEP * NR_128) begin miscompares++; $display("FAIL bp_latency: got %0d want %0d", n, STEP * NR_128); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (bus_a.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, bus_a.out_valid); end
      vectors++; if (bus_a.out_data !== PT) begin miscompares++; $display("FAIL bp_hold_data[%0d]: got %h want %h", i, bus_a.out_data, PT); end
      vectors++; if (bus_a.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold_in_ready[%0d]: got %b want 0", i, bus_a.in_ready); end
      @(posedge clk);
      @(negedge clk);
    end
    bus_a.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++; if (bus_a.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_after_hs_ready: got %b want 1", bus_a.in_ready); end
    @(posedge clk);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    vectors++; if (bus_a.busy !== 1'b1) begin miscompares++; $display("FAIL bp_second_accept: got busy %b want 1", bus_a.busy); end
    vectors++; if (bus_a.key_idx !== 4'd9) begin miscompares++; $display("FAIL bp_second_key: got %0d want 9", bus_a.key_idx); end
    n = 0;
    while (!bus_a.out_valid && n < 60) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    vectors++; if (bus_a.out_data !== PT) begin miscompares++; $display("FAIL bp_second_data: got %h want %h", bus_a.out_data, PT); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    bus_a.out_ready = 1'b1;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = C1_CT;
    @(posedge clk);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    n = 0;
    while (bus_a.key_idx !== 4'd4 && n < 60) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    vectors++; if (bus_a.key_idx !== 4'd4) begin miscompares++; $display("FAIL rst_mid_reach_cnt4: got %0d want 4", bus_a.key_idx); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    vectors++; if (bus_a.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_out_valid: got %b want 0", bus_a.out_valid); end
    vectors++; if (bus_a.busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b want 0", bus_a.busy); end
    vectors++; if (bus_a.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_in_ready: got %b want 1", bus_a.in_ready); end
    decrypt_a(C1_CT, "post_reset");
  endtask

  task automatic test_back_to_back();
    int acc [2];
    int k_acc, k_out, i;
    @(negedge clk);
    bus_a.out_ready = 1'b1;
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = C1_CT;
    acc   = '{0, 0};
    k_acc = 0;
    k_out = 0;
    i     = 0;
    while (k_out < 2 && i < 100) begin
      if (k_acc == 2) bus_a.in_valid = 1'b0;
      else if (bus_a.in_ready) begin acc[k_acc] = cyc; k_acc++; end
      if (bus_a.out_valid) begin
        vectors++; if (bus_a.out_data !== PT) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h want %h", k_out, bus_a.out_data, PT); end
        k_out++;
      end
      @(posedge clk);
      @(negedge clk);
      i++;
    end
    bus_a.in_valid = 1'b0;
    vectors++; if (k_out !== 2) begin miscompares++; $display("FAIL b2b_outputs: got %0d want 2", k_out); end
    vectors++; if (acc[1] - acc[0] !== STEP * NR_128 + 2) begin miscompares++; $display("FAIL b2b_spacing: got %0d want %0d", acc[1] - acc[0], STEP * NR_128 + 2); end
  endtask

  task automatic test_aes256();
    int n;
    @(negedge clk);
    bus_b.out_ready = 1'b1;
    bus_b.in_valid  = 1'b1;
    bus_b.in_data   = C3_CT;
    vectors++; if (bus_b.in_ready !== 1'b1) begin miscompares++; $display("FAIL c3_in_ready: got %b want 1", bus_b.in_ready); end
    @(posedge clk);
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    vectors++; if (bus_b.key_idx !== 4'd13) begin miscompares++; $display("FAIL c3_first_key: got %0d want 13", bus_b.key_idx); end
    n = 0;
    while (!bus_b.out_valid && n < 80) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    vectors++; if (n !== STEP * NR_256) begin miscompares++; $display("FAIL c3_latency: got %0d want %0d", n, STEP * NR_256); end
    vectors++; if (bus_b.out_data !== PT) begin miscompares++; $display("FAIL c3_out_data: got %h want %h", bus_b.out_data, PT); end
    @(posedge clk);
    @(negedge clk);
    vectors++; if (bus_b.busy !== 1'b0) begin miscompares++; $display("FAIL c3_release_busy: got %b want 0", bus_b.busy); end
  endtask

  initial begin
    bus_a.in_valid  = 1'b0;
    bus_a.in_data   = '0;
    bus_a.out_ready = 1'b0;
    bus_b.in_valid  = 1'b0;
    bus_b.in_data   = '0;
    bus_b.out_ready = 1'b0;
    build_sbox();
    expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, NR_128, 1'b0);
    expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, NR_256, 1'b1);

    test_reset();
    test_c1();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_aes256();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_inv_cipher_ctrl.md
Name: aes_inv_cipher_ctrl

Overview:
- Iterative AES decryption sequencer. Loads one 128-bit ciphertext and applies one inverse round per cycle through a shared combinational round datapath: InvShiftRows, then InvSubState, then AddRoundKey, then InvMixColumns.
- Fetches round keys by index from an external expanded-key store.
- Sits between the key-expansion block and the system-level decryption wrapper.

Parameters:
- NR, 10, number of rounds; legal values 10, 12 or 14 (AES-128/192/256).
- CNT_W, 4, width of the round counter and key index; must satisfy 2^CNT_W > NR.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  ciphertext valid.
- in_ready  out  1  block can accept a ciphertext; high only in IDLE.
- in_data  in  [0:127]  ciphertext; byte 0 = bits [0:7].
- key_idx  out  CNT_W  round-key index requested this cycle.
- round_key  in  [0:127]  key for key_idx, combinational from the key store in the same cycle.
- out_valid  out  1  plaintext valid.
- out_ready  in  1  consumer accepts the plaintext.
- out_data  out  [0:127]  plaintext.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high), applies in any state including mid-round:
  - state goes to IDLE; any in-flight block is discarded.
  - out_valid=0, busy=0, out_data=0, round counter=0.
  - in_ready=1 from the first cycle after reset deasserts.
- FSM states: IDLE, ROUND, DONE (plus SUB when AES_DEC_SBOX_PIPE_EN is defined).
- IDLE:
  - key_idx=NR.
  - Accept occurs when in_valid && in_ready: state_reg <= in_data XOR round_key; cnt <= NR-1; go to ROUND.
- ROUND:
  - key_idx=cnt.
  - state_reg <= AddRoundKey(InvSubState(InvShiftRows(state_reg)), round_key).
  - If cnt!=0, the result is additionally passed through InvMixColumns.
  - If cnt!=0: cnt <= cnt-1. If cnt==0: go to DONE.
- DONE:
  - out_valid=1; out_data=state_reg, held stable until out_valid && out_ready.
  - On that handshake, go to IDLE.
  - in_ready=0 in DONE. A new block can be accepted no earlier than the cycle after the output handshake.
- Latency: out_valid rises exactly NR clock edges after the accepting edge (10 for NR=10).
- Throughput: one block per NR+2 cycles with out_ready held high.
- in_valid while busy is ignored; in_data is sampled only on the accepting edge.
- out_data is driven 0 when out_valid=0.
- key_idx is always in the range 0..NR; the key store must return the key combinationally in the same cycle.

Optional Feature:
- Macro: AES_DEC_SBOX_PIPE_EN.
- Defined:
  - A 128-bit register is inserted after InvSubState. Each round spends one cycle in SUB (register the InvSubState output) followed by one cycle in ROUND (AddRoundKey, then InvMixColumns).
  - key_idx=cnt in both cycles.
  - Latency is 2*NR edges.
- Undefined: single-cycle rounds as described in Behaviour; no extra registers.

Decomposition:
- Package aes_dec_pkg holds:
  - FSM state enum (IDLE, SUB, ROUND, DONE).
  - Constants NR_128=10, NR_192=12, NR_256=14.
  - 128-bit block typedef with [0:127] ordering.
- Sub-module aes_inv_round: combinational, one round.
  - Inputs: state, key, last (suppresses InvMixColumns).
  - Instantiates InvShiftRows, InvSubState, InvMixColumns and the key XOR.
  - Under AES_DEC_SBOX_PIPE_EN it is split into pre-sub and post-sub halves.

Test Plan:
- FIPS-197 C.1 vector:
  - Setup: bench key store holds the expansion of key 000102030405060708090a0b0c0d0e0f.
  - Stimulus: in_data=69c4e0d86a7b0430d8cdb78070b4c55a with out_ready=1.
  - Response: out_data=00112233445566778899aabbccddeeff; out_valid exactly 10 edges after accept; key_idx sequence 10,9,...,0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE; assert in_valid with a new block throughout.
  - Response: out_data stable; in_ready=0; second block accepted the cycle after the output handshake.
- Reset mid-operation:
  - Stimulus: assert reset at round cnt=4.
  - Response: next cycle out_valid=0, busy=0, in_ready=1; a following block decrypts correctly.
- Back-to-back with out_ready=1:
  - Stimulus: two C.1 ciphertexts.
  - Response: accept edges 12 cycles apart; both outputs correct.
- NR=14 build, C.3 vector:
  - Setup: key 000102...1f.
  - Stimulus: in_data=8ea2b7ca516745bfeafc49904b496089.
  - Response: out_data=00112233445566778899aabbccddeeff after 14 edges.
- AES_DEC_SBOX_PIPE_EN build:
  - Stimulus: C.1 vector.
  - Response: same plaintext; latency 20 edges; each key_idx value is held for 2 cycles.
